data_ram_ctrl: RTL and testbench
================================

DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, memory depth is 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before each access (0..15).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 ce_i  input  1  access request from the memory-access stage; held stable while stallreq_o=1.
REQ-006 we_i  input  1  1=write, 0=read.
REQ-007 addr_i  input  32  byte address; addr_i[1:0] ignored.
REQ-008 sel_i  input  4  byte lanes, big-endian: sel_i[3]=bits 31:24 ... sel_i[0]=bits 7:0.
REQ-009 data_i  input  32  write data, already lane-replicated by the requester.
REQ-010 data_o  output  32  registered read data.
REQ-011 stallreq_o  output  1  pipeline stall request, combinational.
REQ-012 err_o  output  1  one-cycle address-range error pulse.

Function
REQ-013 FSM states: IDLE, WAIT, DONE.
REQ-014 IDLE, ce_i=1: load wait counter with WAIT_CYCLES, go to WAIT; if WAIT_CYCLES=0, perform access immediately, go to DONE.
REQ-015 WAIT: decrement counter each cycle; on the cycle the counter is 0, perform access and go to DONE.
REQ-016 Access, read: data_o <= mem[word index] (full word, sel_i ignored).
REQ-017 Access, write: for each sel_i[n]=1, write byte lane n of data_i into mem[word index]; other lanes unchanged; data_o unchanged.
REQ-018 Word index = addr_i[DEPTH_LOG2+1:2]; higher bits ignored (address wraps modulo depth).
REQ-019 DONE: unconditional return to IDLE next cycle.
REQ-020 stallreq_o = ce_i AND state != DONE.
REQ-021 Latency: a request first seen in IDLE completes with stallreq_o=0 exactly WAIT_CYCLES+1 cycles later; read data is valid on data_o in the DONE cycle and holds until the next read access.
REQ-022 ce_i dropping to 0 in WAIT (flush): abort to IDLE next edge; no write, data_o unchanged.
REQ-023 Write with sel_i=4'b0000: full handshake, memory unchanged.
REQ-024 Back-to-back requests: a new request is accepted only from IDLE; minimum spacing WAIT_CYCLES+2 cycles.
REQ-025 err_o=0 except as in REQ-031.

Reset
REQ-026 rst low: state=IDLE, counter=0, data_o=32'h0, err_o=0, stallreq_o=0 (forced while rst low).
REQ-027 Reset mid-WAIT: pending access discarded, no write occurs.
REQ-028 Memory array is not reset; contents are preserved across reset.

Configuration
REQ-029 Macro DRAM_ADDR_CHECK_EN selects address-range checking.
REQ-030 Without DRAM_ADDR_CHECK_EN: err_o tied to 0; REQ-018 wrap-around applies to all addresses.
REQ-031 With DRAM_ADDR_CHECK_EN: an access with addr_i[31:DEPTH_LOG2+2] != 0 still completes the full handshake, suppresses the write, loads data_o with 32'h0 on a read, and pulses err_o=1 in the DONE cycle.

Verification
REQ-032 WAIT_CYCLES=2; write addr 0x10, sel 1111, data 0xDEADBEEF; then read 0x10 -> stallreq_o high 3 cycles per access; data_o=0xDEADBEEF in read DONE cycle.
REQ-033 Word 0x20 = 0x11223344; write sel 0100, data 0xAAAAAAAA; read -> 0x11AA3344.
REQ-034 ce_i high 1 cycle then low during WAIT, we_i=1, addr 0x30, data 0xFFFFFFFF -> FSM returns to IDLE; later read of 0x30 returns prior contents.
REQ-035 Reset asserted mid-WAIT of a write -> outputs 0 immediately; memory unchanged; next read latency is exactly WAIT_CYCLES+1.
REQ-036 DEPTH_LOG2=10; write 0x55 to addr 0x1000 -> without macro, read of 0x0 returns 0x55; with DRAM_ADDR_CHECK_EN, write suppressed, err_o pulses, read of 0x1000 returns 0.
REQ-037 WAIT_CYCLES=0; read -> stallreq_o high exactly 1 cycle, data valid the next cycle.

Source files
------------

// File: rtl/data_ram_ctrl.sv
// ============================================================================
// Module   : data_ram_ctrl
// Purpose  : Single-port data RAM behind a wait-state handshake for a pipeline
//            memory-access stage. Each request waits WAIT_CYCLES, then performs
//            one read (full word) or byte-lane write, then returns through DONE.
// Ports    : clk        - clock, rising-edge
//            rst        - asynchronous reset, active low
//            ce_i       - access request (held while stallreq_o=1)
//            we_i       - 1=write, 0=read
//            addr_i     - byte address, [1:0] ignored
//            sel_i      - byte-lane enables, sel_i[3]=bits 31:24
//            data_i     - lane-replicated write data
//            data_o     - registered read data
//            stallreq_o - combinational stall request
//            err_o      - one-cycle address-range error pulse
// Options  : DRAM_ADDR_CHECK_EN - when defined, addresses above the RAM depth
//            are rejected (write suppressed, read returns 0, err_o pulses);
//            otherwise addresses wrap modulo the depth.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_ctrl #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stallreq_o,
  output logic        err_o
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] data_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_range_err;
  logic                  w_access;
  logic                  w_do_write;
  logic                  unused_addr_bits;

  assign w_idx = addr_i[DEPTH_LOG2+1:2];

  // Low byte-offset bits never matter; upper bits matter only with checking.
  assign unused_addr_bits = ^{addr_i[1:0], addr_i[31:DEPTH_LOG2+2]};

`ifdef DRAM_ADDR_CHECK_EN
  assign w_range_err = |addr_i[31:DEPTH_LOG2+2];
`else
  assign w_range_err = 1'b0;
`endif

  // The access fires on the edge that leaves for DONE. The counter is loaded
  // with WAIT_CYCLES and the access happens in the WAIT cycle where the
  // decremented count reaches zero, so the request sees exactly WAIT_CYCLES+1
  // stalled cycles. Gated by rst so nothing is written while reset is held.
  always_comb begin
    w_access = 1'b0;
    if (rst) begin
      case (state_q)
        S_IDLE:  w_access = ce_i && (WAIT_CYCLES == 0);
        S_WAIT:  w_access = ce_i && (cnt_q <= 4'd1);
        default: w_access = 1'b0;
      endcase
    end
  end

  assign w_do_write = w_access & we_i & ~w_range_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ce_i) begin
            if (WAIT_CYCLES == 0) begin
              state_q <= S_DONE;
            end else begin
              cnt_q   <= WAIT_INIT;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!ce_i) begin
            // Flush: abandon the pending access.
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q <= 4'd1) begin
            state_q <= S_DONE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (w_access) begin
        err_q <= w_range_err;
        if (!we_i) begin
          data_q <= w_range_err ? 32'h0 : mem_q[w_idx];
        end
      end
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_i[n]) begin
          mem_q[w_idx][8*n +: 8] <= data_i[8*n +: 8];
        end
      end
    end
  end

  assign data_o     = data_q;
  assign err_o      = err_q;
  assign stallreq_o = rst & ce_i & (state_q != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
// ============================================================================
// Module   : tb_data_ram_ctrl
// Purpose  : Self-checking bench for data_ram_ctrl. One instance with
//            WAIT_CYCLES=2 runs a vector table plus flush, reset and
//            out-of-range sequences; a second instance with WAIT_CYCLES=0
//            checks the zero-wait handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_ram_ctrl;

  logic        clk;
  logic        rst;
  logic        ce_i, we_i;
  logic [31:0] addr_i, data_i;
  logic [3:0]  sel_i;
  logic [31:0] data_o;
  logic        stallreq_o, err_o;

  logic        ce0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  sel0;
  logic [31:0] data0;
  logic        stall0, err0;

  int n_tests = 0;
  int n_fail  = 0;

  data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .data_i(data_i), .data_o(data_o),
    .stallreq_o(stallreq_o), .err_o(err_o)
  );

  data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we0), .addr_i(addr0),
    .sel_i(sel0), .data_i(wdata0), .data_o(data0),
    .stallreq_o(stall0), .err_o(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full handshake on the WAIT_CYCLES=2 instance. Returns the number of
  // stalled cycles and the outputs seen in the first non-stalled (DONE) cycle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wd, output int stalls,
                        output logic [31:0] dq, output logic eq);
    @(negedge clk);
    ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; data_i = wd;
    #1;
    stalls = 0;
    while (stallreq_o && stalls < 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    dq = data_o;
    eq = err_o;
    ce_i = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int          st;
    logic [31:0] d;
    logic        e;

    vecs[0]  = '{1'b1, 32'h10,  4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 32'h10,  4'b0000, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,  4'b1111, 32'h11223344, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h20,  4'b0100, 32'hAAAAAAAA, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h20,  4'b1111, 32'h0,        32'h11AA3344, 1'b0};
    vecs[5]  = '{1'b1, 32'h30,  4'b1111, 32'h12345678, 32'h11AA3344, 1'b0};
    vecs[6]  = '{1'b1, 32'h24,  4'b1111, 32'hA5A5A5A5, 32'h11AA3344, 1'b0};
    vecs[7]  = '{1'b1, 32'h24,  4'b0000, 32'hFFFFFFFF, 32'h11AA3344, 1'b0};
    vecs[8]  = '{1'b0, 32'h24,  4'b0000, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[9]  = '{1'b1, 32'h10,  4'b1001, 32'hFF0000EE, 32'hA5A5A5A5, 1'b0};
    vecs[10] = '{1'b0, 32'h13,  4'b0000, 32'h0,        32'hFFADBEEE, 1'b0};
    vecs[11] = '{1'b1, 32'hFFC, 4'b1111, 32'h0BADF00D, 32'hFFADBEEE, 1'b0};
    vecs[12] = '{1'b0, 32'hFFC, 4'b0000, 32'h0,        32'h0BADF00D, 1'b0};

    rst = 1'b0;
    ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
    ce0 = 1'b0; we0 = 1'b0; addr0 = '0; sel0 = '0; wdata0 = '0;
    repeat (2) @(negedge clk);
    ce_i = 1'b1;
    #1;
    chk("reset_data",  data_o, 32'h0);
    chk("reset_err",   {31'h0, err_o}, 32'h0);
    chk("reset_stall", {31'h0, stallreq_o}, 32'h0);
    ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Vector table
    for (int i = 0; i < 13; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, st, d, e);
      chk($sformatf("vec%0d_stalls", i), st, 32'd3);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
    end

    // Flush: request for one cycle then drop ce_i during WAIT
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h30; sel_i = 4'b1111; data_i = 32'hFFFFFFFF;
    #1;
    chk("flush_stall_req", {31'h0, stallreq_o}, 32'h1);
    @(negedge clk);
    ce_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("flush_data_hold", data_o, 32'h0BADF00D);
    access(1'b0, 32'h30, 4'b0000, 32'h0, st, d, e);
    chk("flush_rd_stalls", st, 32'd3);
    chk("flush_rd_data", d, 32'h12345678);

    // Reset during WAIT of a write
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h30; sel_i = 4'b1111; data_i = 32'hFFFFFFFF;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_data",  data_o, 32'h0);
    chk("rstmid_stall", {31'h0, stallreq_o}, 32'h0);
    chk("rstmid_err",   {31'h0, err_o}, 32'h0);
    @(negedge clk);
    ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    access(1'b0, 32'h30, 4'b0000, 32'h0, st, d, e);
    chk("rstmid_rd_stalls", st, 32'd3);
    chk("rstmid_rd_data", d, 32'h12345678);

    // Address beyond the RAM depth
    access(1'b1, 32'h0, 4'b1111, 32'h11111111, st, d, e);
    access(1'b1, 32'h1000, 4'b1111, 32'h00000055, st, d, e);
    chk("oor_wr_stalls", st, 32'd3);
    chk("oor_wr_data", d, 32'h12345678);
`ifdef DRAM_ADDR_CHECK_EN
    chk("oor_wr_err", {31'h0, e}, 32'h1);
    @(negedge clk);
    #1;
    chk("oor_err_pulse_end", {31'h0, err_o}, 32'h0);
    access(1'b0, 32'h1000, 4'b0000, 32'h0, st, d, e);
    chk("oor_rd_data", d, 32'h0);
    chk("oor_rd_err", {31'h0, e}, 32'h1);
    access(1'b0, 32'h0, 4'b0000, 32'h0, st, d, e);
    chk("oor_word0_kept", d, 32'h11111111);
    chk("oor_word0_err", {31'h0, e}, 32'h0);
`else
    chk("wrap_wr_err", {31'h0, e}, 32'h0);
    access(1'b0, 32'h0, 4'b0000, 32'h0, st, d, e);
    chk("wrap_rd_data", d, 32'h00000055);
    chk("wrap_rd_err", {31'h0, e}, 32'h0);
`endif

    // Zero-wait instance: one stalled cycle, data valid the next cycle
    @(negedge clk);
    ce0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; sel0 = 4'b1111; wdata0 = 32'h600DCAFE;
    #1;
    chk("w0_wr_stall", {31'h0, stall0}, 32'h1);
    @(negedge clk);
    #1;
    chk("w0_wr_done", {31'h0, stall0}, 32'h0);
    ce0 = 1'b0;
    @(negedge clk);
    ce0 = 1'b1; we0 = 1'b0;
    #1;
    chk("w0_rd_stall", {31'h0, stall0}, 32'h1);
    @(negedge clk);
    #1;
    chk("w0_rd_done", {31'h0, stall0}, 32'h0);
    chk("w0_rd_data", data0, 32'h600DCAFE);
    ce0 = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
